uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Serial-to-parallel UART receive stage, the downstream consumer of the transmit block's tx_data line.
- Frame format: 8N1. One start bit (0), 8 data bits LSB first, one stop bit (1).
- Clocking: runs on the system clock at CLKS_PER_BIT times the bit rate. Validates the start bit at mid-bit, samples each bit at its centre, checks the stop bit.
- Output: the received byte in a holding register with a valid/acknowledge handshake, plus framing and overrun status.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Legal range 4..1023; must be even.
- SYNC_STAGES, 2: synchroniser flops on rx_data. Legal range 2..3.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  1  serial line. Idle high; asynchronous to clk.
- rx_ack  input  1  consumer has taken data_out. Meaningful only while rx_valid=1.
- data_out  output  8  received byte (receive holding register).
- rx_valid  output  1  data_out holds an unacknowledged byte.
- frame_err  output  1  stop bit of the byte in data_out was sampled 0.
- overrun  output  1  sticky: a byte was overwritten before being acknowledged.
- rx_busy  output  1  a frame is in progress (state is not IDLE).

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - Synchroniser flops = 1; state = IDLE; bit counter = 0; clock counter = 0; shift register = 0.
  - data_out = 8'h00; rx_valid = 0; frame_err = 0; overrun = 0; rx_busy = 0.
  - Reset mid-frame abandons the frame; no partial byte is ever loaded.
- Synchroniser: rxs is rx_data after SYNC_STAGES flops. All decisions use rxs only.
- FSM states:
  - IDLE: rxs=0 moves to START; clock counter cleared.
  - START: count CLKS_PER_BIT/2 cycles, then sample rxs.
    - rxs=1: treat as glitch, return to IDLE; no flags change.
    - rxs=0: move to DATA; clock counter and bit counter cleared.
  - DATA: every CLKS_PER_BIT cycles, sample rxs into the shift register (right shift, new bit enters bit 7, so LSB is first).
    - After the 8th sample, move to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - Load stage (both outcomes): data_out = shift register; rx_valid = 1; frame_err = ~rxs.
    - rxs=1: move to IDLE.
    - rxs=0: move to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then move to IDLE. This covers break conditions and prevents a false start on a held-low line.
- Latency: rx_valid rises on the clk edge after the stop-bit sample point. That point is SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after the falling edge of rx_data.
- Handshake:
  - rx_valid is a level. rx_ack=1 while rx_valid=1 clears rx_valid and overrun on the next edge.
  - data_out and frame_err hold until the next load.
  - rx_ack while rx_valid=0 is ignored.
- Overrun:
  - If a load occurs while rx_valid=1 and rx_ack=0 in that cycle: overrun = 1, data_out and frame_err are overwritten by the new byte, rx_valid stays 1.
  - If load and rx_ack coincide: the load wins. rx_valid stays 1, overrun does not set, and an existing overrun is cleared.
- rx_busy = 1 in START, DATA, STOP, WAIT_HIGH.
- Counters:
  - Clock counter: ceil(log2(CLKS_PER_BIT)) bits. It wraps to 0 at each sample point; it never free-runs in IDLE.
  - Bit counter: 4 bits, counts 0..8.

Test Plan (CLKS_PER_BIT=16, one bit = 16 clk):
- Reset: assert rst_n=0 mid-DATA of a frame → outputs 0 immediately, rx_busy=0. After release, line held 1 for 200 clk → rx_valid stays 0.
- Single frame: drive 8'hA5 as 8N1 → rx_valid=1 at ~154 clk after the start edge; data_out=8'hA5, frame_err=0. Pulse rx_ack → rx_valid=0 next clk.
- Glitch rejection: rx_data low for 4 clk then high → state returns to IDLE, rx_valid=0, no flags set.
- Framing error: send 8'h3C with stop bit 0, line held low 40 clk, then high, then send 8'h81 → first frame gives data_out=8'h3C, frame_err=1. No new frame starts until the line goes high. Second frame gives data_out=8'h81, frame_err=0.
- Overrun: send 8'h11, then 8'h22 back-to-back with no ack → data_out=8'h22, rx_valid=1, overrun=1. rx_ack → overrun=0, rx_valid=0.
- Ack/load collision: hold rx_valid from 8'h55 and assert rx_ack in the exact load cycle of 8'hAA → data_out=8'hAA, rx_valid=1, overrun=0.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronises rx_data, validates the start bit at mid-bit,
// samples each bit at its centre and hands the byte over with a valid/ack handshake.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_data,
  input  logic       rx_ack,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     rxs;
  logic [CNT_W-1:0]         clkCnt_q, clkCnt_d;
  logic [3:0]               bitCnt_q, bitCnt_d;
  logic [7:0]               shift_q, shift_d;
  logic [7:0]               data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     ferr_q, ferr_d;
  logic                     ovr_q, ovr_d;
  logic                     load;

  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_data};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      clkCnt_q <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      clkCnt_q <= clkCnt_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    clkCnt_d = clkCnt_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        clkCnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (clkCnt_q == HALF_LAST) begin
          clkCnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            bitCnt_d = '0;
          end
        end else begin
          clkCnt_d = clkCnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (clkCnt_q == BIT_LAST) begin
          clkCnt_d = '0;
          shift_d  = {rxs, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 4'd1;
          if (bitCnt_q == 4'd7) state_d = STOP;
        end else begin
          clkCnt_d = clkCnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (clkCnt_q == BIT_LAST) begin
          clkCnt_d = '0;
          load     = 1'b1;
          state_d  = rxs ? IDLE : WAIT_HIGH;
        end else begin
          clkCnt_d = clkCnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A load always wins over a coincident ack; overrun then reflects whether that ack arrived.
  always_comb begin
    data_d  = data_q;
    ferr_d  = ferr_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (load) begin
      data_d  = shift_q;
      ferr_d  = ~rxs;
      valid_d = 1'b1;
      if (valid_q) ovr_d = ~rx_ack;
    end else if (valid_q && rx_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign data_out  = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized frames,
// all compared against a frame-level model of the receive holding register.
module tb_uart_receiver;

   localparam int CPB      = 16;
   localparam int SYNC     = 2;
   localparam int FRAME    = 10 * CPB;
   // Stop-bit sample lands SYNC + CPB/2 + 9*CPB cycles after the start edge; the load
   // is on the following edge, so an ack driven in this cycle index coincides with it.
   localparam int LOAD_CYC = SYNC + CPB / 2 + 9 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_data = 1'b1;
   logic       rx_ack = 1'b0;
   logic [7:0] data_out;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       rx_busy;

   int checks = 0;
   int errors = 0;
   int riseCyc;

   // Reference model of what the consumer should see
   logic [7:0] expData = 8'h00;
   bit         expValid = 1'b0;
   bit         expFerr = 1'b0;
   bit         expOverrun = 1'b0;

   uart_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx_data(rx_data),
      .rx_ack(rx_ack),
      .data_out(data_out),
      .rx_valid(rx_valid),
      .frame_err(frame_err),
      .overrun(overrun),
      .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   // Guard against a stuck run
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point for every check in this bench
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Compares all handshake outputs against the model
   task automatic checkModel(input string where);
      checkOutput({where, " data_out"}, {24'h0, data_out}, {24'h0, expData});
      checkOutput({where, " rx_valid"}, {31'h0, rx_valid}, {31'h0, expValid});
      checkOutput({where, " frame_err"}, {31'h0, frame_err}, {31'h0, expFerr});
      checkOutput({where, " overrun"}, {31'h0, overrun}, {31'h0, expOverrun});
   endtask

   // Model of one completed frame arriving at the holding register
   function automatic void modelLoad(input logic [7:0] value, input bit stopBit, input bit ackCoincide);
      if (expValid) expOverrun = !ackCoincide;
      expValid = 1'b1;
      expData  = value;
      expFerr  = !stopBit;
   endfunction

   function automatic void modelAck();
      if (expValid) begin
         expValid   = 1'b0;
         expOverrun = 1'b0;
      end
   endfunction

   function automatic void modelReset();
      expData    = 8'h00;
      expValid   = 1'b0;
      expFerr    = 1'b0;
      expOverrun = 1'b0;
   endfunction

   // Drives one 8N1 frame bit by bit; optionally pulses ack at cycle ackCyc or
   // asserts reset at cycle abortCyc. Leaves the line at the stop-bit level.
   task automatic applyStimulus(input logic [7:0] value, input bit stopBit, input int ackCyc, input int abortCyc);
      logic [9:0] frameBits;
      frameBits = {stopBit, value, 1'b0};
      riseCyc = -1;
      for (int cyc = 0; cyc < FRAME; cyc++) begin
         @(negedge clk);
         if (riseCyc < 0 && !expValid && rx_valid === 1'b1) riseCyc = cyc;
         if (cyc == abortCyc) begin
            rst_n   = 1'b0;
            rx_data = 1'b1;
            rx_ack  = 1'b0;
            #1;
            checkOutput("reset data_out", {24'h0, data_out}, 32'h0);
            checkOutput("reset rx_valid", {31'h0, rx_valid}, 32'h0);
            checkOutput("reset frame_err", {31'h0, frame_err}, 32'h0);
            checkOutput("reset overrun", {31'h0, overrun}, 32'h0);
            checkOutput("reset rx_busy", {31'h0, rx_busy}, 32'h0);
            modelReset();
            return;
         end
         rx_data = frameBits[cyc / CPB];
         rx_ack  = (cyc == ackCyc);
         if (cyc == 5 * CPB) checkOutput("busy mid-frame", {31'h0, rx_busy}, 32'h1);
      end
      modelLoad(value, stopBit, ackCyc == LOAD_CYC);
   endtask

   task automatic pulseAck();
      @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      modelAck();
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      checkModel("por");
      checkOutput("por rx_busy", {31'h0, rx_busy}, 32'h0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checkModel("idle");

      // Single frame, latency, ack, and ack while not valid
      applyStimulus(8'hA5, 1'b1, -1, -1);
      checkOutput("latency in window", {31'h0, (riseCyc >= LOAD_CYC && riseCyc <= LOAD_CYC + 2)}, 32'h1);
      @(negedge clk);
      checkModel("A5");
      pulseAck();
      checkModel("A5 acked");
      pulseAck();
      checkModel("ack ignored");

      // Glitch shorter than half a bit
      @(negedge clk);
      rx_data = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("glitch busy", {31'h0, rx_busy}, 32'h1);
      rx_data = 1'b1;
      repeat (30) @(negedge clk);
      checkModel("glitch");
      checkOutput("glitch idle", {31'h0, rx_busy}, 32'h0);

      // Framing error with line held low, then a clean frame
      applyStimulus(8'h3C, 1'b0, -1, -1);
      repeat (40) @(negedge clk);
      checkModel("3C ferr");
      checkOutput("held low busy", {31'h0, rx_busy}, 32'h1);
      rx_data = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("line high idle", {31'h0, rx_busy}, 32'h0);
      pulseAck();
      applyStimulus(8'h81, 1'b1, -1, -1);
      @(negedge clk);
      checkModel("81");

      // Overrun with back-to-back frames, cleared by ack
      pulseAck();
      applyStimulus(8'h11, 1'b1, -1, -1);
      applyStimulus(8'h22, 1'b1, -1, -1);
      @(negedge clk);
      checkModel("overrun");
      pulseAck();
      checkModel("overrun acked");

      // Ack coinciding with a load clears an existing overrun and keeps valid
      applyStimulus(8'h55, 1'b1, -1, -1);
      applyStimulus(8'h66, 1'b1, -1, -1);
      applyStimulus(8'hAA, 1'b1, LOAD_CYC, -1);
      @(negedge clk);
      checkModel("collision");

      // Reset mid-DATA abandons the frame
      applyStimulus(8'hC3, 1'b1, -1, 3 * CPB + 7);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      checkModel("post reset");
      checkOutput("post reset busy", {31'h0, rx_busy}, 32'h0);

      // Randomized frames, gaps, stop bits and acks
      for (int n = 0; n < 24; n++) begin
         logic [7:0] value;
         bit         stopBit;
         int         gap;
         int         lowHold;
         int         ackCyc;
         value   = 8'($urandom);
         stopBit = ($urandom_range(0, 4) != 0);
         gap     = stopBit ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 30));
         lowHold = stopBit ? 0 : int'($urandom_range(0, 20));
         ackCyc  = ($urandom_range(0, 3) == 0) ? LOAD_CYC : -1;
         applyStimulus(value, stopBit, ackCyc, -1);
         repeat (lowHold) @(negedge clk);
         if (gap > 0) begin
            rx_data = 1'b1;
            repeat (gap) @(negedge clk);
            checkModel("random");
            if ($urandom_range(0, 1) == 1) begin
               pulseAck();
               checkModel("random acked");
            end
         end
      end
      @(negedge clk);
      rx_data = 1'b1;
      checkModel("final");
      pulseAck();
      checkModel("final acked");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
